// File: rtl/sort_loader_if.sv
// rtl/sort_loader_if.sv - handshake and data bundle between the round loader and its neighbours
interface sort_loader_if #(
    parameter int DATA_W = 4,
    parameter int LFSR_W = 16
);
    logic              start;
    logic              seed_load;
    logic [LFSR_W-1:0] seed_in;
    logic              sorting_done;
    logic              sorter_rst;
    logic              load_num;
    logic [DATA_W-1:0] random_num;
    logic              sort_trigger;
    logic              busy;
    logic              done;
    logic              timeout;

    modport master (
        output start, seed_load, seed_in, sorting_done,
        input  sorter_rst, load_num, random_num, sort_trigger, busy, done, timeout
    );

    modport slave (
        input  start, seed_load, seed_in, sorting_done,
        output sorter_rst, load_num, random_num, sort_trigger, busy, done, timeout
    );
endinterface

// File: rtl/sort_loader.sv
// rtl/sort_loader.sv - clears the sorter, feeds it NUM_COUNT random digits, then requests a sort
module sort_loader #(
    parameter int              NUM_COUNT  = 4,
    parameter int              DATA_W     = 4,
    parameter int              MAX_VAL    = 10,
    parameter int              LFSR_W     = 16,
    parameter logic [LFSR_W-1:0] SEED     = 16'hACE1,
    parameter int              GAP_CYCLES = 2,
    parameter int              SORT_MAX   = 64
) (
    input  logic        clk,
    input  logic        rst,
    sort_loader_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, GAP, SORT, FINISH} state_t;

    localparam int LC_W = $clog2(NUM_COUNT + 1);
    localparam int GC_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int SC_W = (SORT_MAX > 1) ? $clog2(SORT_MAX) : 1;

    localparam logic [LC_W-1:0]   LOAD_LAST = LC_W'(NUM_COUNT - 1);
    localparam logic [GC_W-1:0]   GAP_LAST  = (GAP_CYCLES > 0) ? GC_W'(GAP_CYCLES - 1) : '0;
    localparam logic [SC_W-1:0]   SORT_LAST = SC_W'(SORT_MAX - 1);
    localparam logic [LFSR_W-1:0] TAP_MASK  = LFSR_W'(16'hB400);
    localparam logic [4:0]        MAX_V     = 5'(MAX_VAL);

    state_t            state, state_nxt;
    logic [LC_W-1:0]   load_cnt;
    logic [GC_W-1:0]   gap_cnt;
    logic [SC_W-1:0]   sort_cnt;
    logic [LFSR_W-1:0] lfsr;
    logic [DATA_W-1:0] random_q;
    logic              timeout_q;

    logic       load_last;
    logic       gap_end;
    logic       sort_end;
    logic [4:0] nib;
    logic [4:0] digit;

    assign load_last = (load_cnt == LOAD_LAST);
    assign gap_end   = (gap_cnt == GAP_LAST);
    assign sort_end  = (sort_cnt == SORT_LAST);
    assign nib       = {1'b0, lfsr[3:0]};
    assign digit     = (nib >= MAX_V) ? (nib - MAX_V) : nib;

    // State register; reset aborts any round in flight without a done pulse
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode for the clear / load / gap / sort / finish round
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = CLEAR;
            CLEAR:   state_nxt = LOAD;
            LOAD: begin
                if (load_last)           state_nxt = SORT;
                else if (GAP_CYCLES > 0) state_nxt = GAP;
                else                     state_nxt = LOAD;
            end
            GAP:     if (gap_end) state_nxt = LOAD;
            SORT:    if (bus.sorting_done || sort_end) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes decoded straight from the state register, so no input reaches an output combinationally
    always_comb begin
        bus.sorter_rst   = 1'b0;
        bus.load_num     = 1'b0;
        bus.sort_trigger = 1'b0;
        bus.done         = 1'b0;
        bus.busy         = (state != IDLE);
        case (state)
            CLEAR:   bus.sorter_rst   = 1'b1;
            LOAD:    bus.load_num     = 1'b1;
            SORT:    bus.sort_trigger = 1'b1;
            FINISH:  bus.done         = 1'b1;
            default: ;
        endcase
    end

    assign bus.random_num = random_q;
    assign bus.timeout    = timeout_q;

    // Round counters, captured digit and sticky timeout flag
    always_ff @(posedge clk) begin
        if (rst) begin
            load_cnt  <= '0;
            gap_cnt   <= '0;
            sort_cnt  <= '0;
            random_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == CLEAR)     load_cnt <= '0;
            else if (state == LOAD) load_cnt <= load_cnt + LC_W'(1);

            if (state == GAP && !gap_end) gap_cnt <= gap_cnt + GC_W'(1);
            else                          gap_cnt <= '0;

            if (state == SORT) sort_cnt <= sort_cnt + SC_W'(1);
            else               sort_cnt <= '0;

            if (state_nxt == LOAD) random_q <= DATA_W'(digit);

            if (state == IDLE && bus.start)
                timeout_q <= 1'b0;
            else if (state == SORT && !bus.sorting_done && sort_end)
                timeout_q <= 1'b1;
        end
    end

    // Free-running Galois LFSR; a zero seed is swapped for SEED so the register never locks up
    always_ff @(posedge clk) begin
        if (rst)
            lfsr <= SEED;
        else if (bus.seed_load)
            lfsr <= (bus.seed_in == '0) ? SEED : bus.seed_in;
        else
            lfsr <= lfsr[0] ? ((lfsr >> 1) ^ TAP_MASK) : (lfsr >> 1);
    end
endmodule

// File: tb/tb_sort_loader.sv
// tb/tb_sort_loader.sv - self-checking bench for sort_loader
module tb_sort_loader;
    logic clk;
    logic rst;

    sort_loader_if #(.DATA_W(4), .LFSR_W(16)) bus ();

    sort_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       sdone;
        logic [5:0] exp;
    } trow_t;

    typedef struct {
        logic [15:0] seed;
        logic [3:0]  exp;
    } drow_t;

    trow_t trows[17];
    drow_t drows[16];

    int   checks = 0;
    int   errors = 0;
    int   loads_seen = 0;
    int   dones_seen = 0;
    bit   sb_on = 1'b0;
    logic [3:0] sb_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] outs();
        return {bus.sorter_rst, bus.load_num, bus.sort_trigger, bus.done, bus.busy, bus.timeout};
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    task automatic wait_idle(input string name, input int limit);
        int n = 0;
        while (bus.busy && n < limit) begin
            tick();
            n++;
        end
        check(name, 32'(bus.busy), 32'd0);
    endtask

    task automatic run_timing(input bit inject);
        for (int i = 0; i < 17; i++) begin
            bus.start        = trows[i].start | (inject && (i == 3 || i == 4));
            bus.sorting_done = trows[i].sdone;
            check(inject ? "timing_gap_start" : "timing", 32'(outs()), 32'(trows[i].exp));
            tick();
        end
        bus.start        = 1'b0;
        bus.sorting_done = 1'b0;
    endtask

    // Scoreboard for captured digits plus digit range and pulse counting
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.load_num) begin
                loads_seen++;
                checks++;
                if (bus.random_num > 4'd9) begin
                    errors++;
                    $display("FAIL digit_range: got %0d expected <=9", bus.random_num);
                end
                if (sb_on) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL digit_sb: got %0d expected no load", bus.random_num);
                    end else begin
                        logic [3:0] e;
                        e = sb_q.pop_front();
                        if (bus.random_num !== e) begin
                            errors++;
                            $display("FAIL digit_sb: got %0d expected %0d", bus.random_num, e);
                        end
                    end
                end
            end
            if (bus.done) dones_seen++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int st_cnt;
        int n;
        int d0;

        for (int i = 0; i < 17; i++) begin
            trows[i].start = (i == 0);
            trows[i].sdone = (i == 14);
            trows[i].exp   = {(i == 1),
                              (i == 2 || i == 5 || i == 8 || i == 11),
                              (i >= 12 && i <= 14),
                              (i == 15),
                              (i >= 1 && i <= 15),
                              1'b0};
        end
        for (int i = 0; i < 16; i++) begin
            drows[i].seed = {12'h5A3, 4'(i)};
            drows[i].exp  = (i >= 10) ? 4'(i - 10) : 4'(i);
        end

        bus.start        = 1'b0;
        bus.seed_load    = 1'b0;
        bus.seed_in      = '0;
        bus.sorting_done = 1'b0;
        rst              = 1'b1;

        // Reset
        tick(); tick(); tick();
        check("reset_outs", 32'(outs()), 32'd0);
        check("reset_random", 32'(bus.random_num), 32'd0);
        check("reset_lfsr", 32'(dut.lfsr), 32'hACE1);
        rst = 1'b0;
        tick();

        // Round timing, then same round with start pulses during GAP
        run_timing(1'b0);
        loads_seen = 0;
        run_timing(1'b1);
        check("gap_start_loads", loads_seen, 4);

        // Seed handling
        bus.seed_load = 1'b1;
        bus.seed_in   = 16'h0000;
        tick();
        check("seed_zero", 32'(dut.lfsr), 32'hACE1);
        bus.seed_in = 16'h1234;
        tick();
        bus.seed_load = 1'b0;
        check("seed_load", 32'(dut.lfsr), 32'h1234);
        tick();
        check("lfsr_step", 32'(dut.lfsr), 32'(lfsr_step(16'h1234)));

        // Digit map: one seeded nibble per load, four loads per round
        bus.sorting_done = 1'b1;
        sb_on = 1'b1;
        for (int g = 0; g < 4; g++) begin
            bus.start     = 1'b1;
            bus.seed_load = 1'b1;
            bus.seed_in   = drows[4*g].seed;
            sb_q.push_back(drows[4*g].exp);
            tick();
            bus.start     = 1'b0;
            bus.seed_load = 1'b0;
            for (int j = 1; j < 4; j++) begin
                tick(); tick();
                bus.seed_load = 1'b1;
                bus.seed_in   = drows[4*g+j].seed;
                sb_q.push_back(drows[4*g+j].exp);
                tick();
                bus.seed_load = 1'b0;
            end
            wait_idle("digit_round_idle", 40);
        end
        sb_on = 1'b0;
        check("digit_sb_drained", sb_q.size(), 0);

        // Timeout
        bus.sorting_done = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        st_cnt = 0;
        n = 0;
        while (!bus.done && n < 200) begin
            if (bus.sort_trigger) st_cnt++;
            tick();
            n++;
        end
        check("timeout_done_seen", 32'(bus.done), 32'd1);
        check("timeout_trigger_len", st_cnt, 64);
        check("timeout_flag", 32'(bus.timeout), 32'd1);
        tick();
        check("timeout_after_done", 32'(outs()), 32'h01);
        tick(); tick();
        check("timeout_sticky", 32'(bus.timeout), 32'd1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("timeout_cleared", 32'(outs()), 32'h22);
        bus.sorting_done = 1'b1;
        wait_idle("timeout_next_idle", 40);

        // Reset mid-round
        bus.sorting_done = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 0;
        while (!bus.sort_trigger && n < 40) begin
            tick();
            n++;
        end
        check("midrst_in_sort", 32'(bus.sort_trigger), 32'd1);
        tick(); tick();
        d0 = dones_seen;
        rst = 1'b1;
        tick();
        check("midrst_outs", 32'(outs()), 32'd0);
        check("midrst_random", 32'(bus.random_num), 32'd0);
        check("midrst_state", 32'(dut.state), 32'd0);
        rst = 1'b0;
        tick(); tick(); tick();
        check("midrst_no_done", dones_seen, d0);
        bus.sorting_done = 1'b1;
        loads_seen = 0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_idle("midrst_round_idle", 40);
        check("midrst_loads", loads_seen, 4);
        check("midrst_done", dones_seen, d0 + 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
